// File: rtl/clk_wiz_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : clk_wiz_pkg
//  Purpose  : Shared constants, lock-state encoding and parameter helpers for
//             the counter-based EPD clock generator.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package clk_wiz_pkg;

  localparam int CLK_IN_HZ       = 200_000_000;
  localparam int DIV_EPP         = 6;   // 200 MHz / 6 = 33.33 MHz
  localparam int PHASE_EPP       = 3;   // half a period of lag = 180 deg
  localparam int LOCK_CYCLES_DEF = 64;

  typedef enum logic [0:0] {
    LOCK_ACQUIRE = 1'b0,
    LOCK_DONE    = 1'b1
  } lock_state_e;

  // A divider ratio is usable only if it is even (exact 50% duty) and >= 2.
  function automatic bit div_ok(input int div);
    return (div >= 2) && ((div % 2) == 0);
  endfunction

  // Counter preload that makes the output lag a zero-start divider by
  // 'phase' input cycles.
  function automatic int start_count(input int div, input int phase);
    return (div - phase) % div;
  endfunction

endpackage
`default_nettype wire

// File: rtl/clk_wiz_if.sv
`default_nettype none
// ============================================================================
//  Module   : clk_wiz_if
//  Purpose  : Output bundle of the clock generator.
//  Signals  : clk_out1 - core logic clock
//             clk_out2 - phase-shifted panel XCL clock
//             locked   - outputs running and valid
//  Modports : master (generator side, drives), slave (consumer side)
//  Revision : 1.0  initial release
// ============================================================================
interface clk_wiz_if;
  logic clk_out1;
  logic clk_out2;
  logic locked;

  modport master (output clk_out1, output clk_out2, output locked);
  modport slave  (input  clk_out1, input  clk_out2, input  locked);
endinterface
`default_nettype wire

// File: rtl/clk_div_phase.sv
`default_nettype none
// ============================================================================
//  Module   : clk_div_phase
//  Purpose  : Even-ratio clock divider with a programmable start count.
//             Output is registered and high while the next count is in the
//             lower half of 0..DIV-1, giving exactly DIV/2 high, DIV/2 low.
//  Ports    : clk  in  1  input clock
//             en   in  1  run enable; 0 holds count at 0 and q low
//             q    out 1  divided clock
//  Revision : 1.0  initial release
// ============================================================================
module clk_div_phase
  import clk_wiz_pkg::*;
#(
  parameter int DIV   = DIV_EPP,
  parameter int START = 0
) (
  input  logic clk,
  input  logic en,
  output logic q
);

  localparam int            CW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] C_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] C_START = CW'(START);
  localparam logic [CW-1:0] C_HALF  = CW'(DIV / 2);

  logic [CW-1:0] count_q, count_d;
  logic          run_q,   run_d;
  logic          q_q,     q_d;

  // run_q remembers whether the previous edge was enabled, so the first
  // enabled edge loads START instead of incrementing from the idle 0.
  always_comb begin
    count_d = '0;
    run_d   = 1'b0;
    q_d     = 1'b0;
    if (en) begin
      run_d = 1'b1;
      if (!run_q) begin
        count_d = C_START;
      end else if (count_q == C_LAST) begin
        count_d = '0;
      end else begin
        count_d = count_q + CW'(1);
      end
      q_d = (count_d < C_HALF);
    end
  end

  // No reset input: en is low throughout reset, which clears every flop.
  always_ff @(posedge clk) begin
    count_q <= count_d;
    run_q   <= run_d;
    q_q     <= q_d;
  end

  assign q = q_q;

endmodule
`default_nettype wire

// File: rtl/clk_wiz.sv
`default_nettype none
// ============================================================================
//  Module   : clk_wiz
//  Purpose  : Behavioural clock generator for the EPD panel driver. Divides
//             the board oscillator into the core clock (clk_out1) and the
//             phase-shifted panel XCL clock (clk_out2), gated until a fixed
//             lock delay after reset release.
//  Ports    : clk_in1_p in  1  oscillator, positive leg (the only clock)
//             clk_in1_n in  1  oscillator, negative leg (not used by logic)
//             resetn    in  1  synchronous active-low reset
//             out_if    master clk_wiz_if: clk_out1, clk_out2, locked
//  Revision : 1.0  initial release
// ============================================================================
module clk_wiz
  import clk_wiz_pkg::*;
#(
  parameter int DIV1        = DIV_EPP,
  parameter int DIV2        = DIV_EPP,
  parameter int PHASE2      = PHASE_EPP,
  parameter int LOCK_CYCLES = LOCK_CYCLES_DEF
) (
  input  logic      clk_in1_p,
  input  logic      clk_in1_n,
  input  logic      resetn,
  clk_wiz_if.master out_if
);

  // Elaboration-time parameter screening.
  if (!div_ok(DIV1)) begin : g_bad_div1
    $error("clk_wiz: DIV1 must be even and >= 2");
  end
  if (!div_ok(DIV2)) begin : g_bad_div2
    $error("clk_wiz: DIV2 must be even and >= 2");
  end
  if ((PHASE2 < 0) || (PHASE2 >= DIV2)) begin : g_bad_phase2
    $error("clk_wiz: PHASE2 must be in 0..DIV2-1");
  end
  if (LOCK_CYCLES < 1) begin : g_bad_lock
    $error("clk_wiz: LOCK_CYCLES must be >= 1");
  end

  localparam int            LW     = $clog2(LOCK_CYCLES + 1);
  localparam logic [LW-1:0] C_LOCK = LW'(LOCK_CYCLES);
  localparam int            START2 = start_count(DIV2, PHASE2);

  logic clk;
  assign clk = clk_in1_p;

  // The negative leg only exists for pin compatibility.
  logic unused_clk_in1_n;
  assign unused_clk_in1_n = clk_in1_n;

  logic [LW-1:0] lock_cnt_q, lock_cnt_d;
  lock_state_e   state_q,    state_d;
  logic          div_en;
  logic          q1, q2;

  // Next state assuming resetn is high; the reset itself is applied in the
  // register process below.
  always_comb begin
    lock_cnt_d = (lock_cnt_q == C_LOCK) ? lock_cnt_q : lock_cnt_q + LW'(1);
    state_d    = state_q;
    case (state_q)
      LOCK_ACQUIRE: if (lock_cnt_d == C_LOCK) state_d = LOCK_DONE;
      LOCK_DONE:    state_d = LOCK_DONE;
      default:      state_d = LOCK_ACQUIRE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      lock_cnt_q <= '0;
      state_q    <= LOCK_ACQUIRE;
    end else begin
      lock_cnt_q <= lock_cnt_d;
      state_q    <= state_d;
    end
  end

  // Dividers are enabled by the value locked takes at this edge, so they
  // start on the lock edge itself and drop on the same edge a reset lands.
  assign div_en = resetn && (state_d == LOCK_DONE);

  clk_div_phase #(
    .DIV   (DIV1),
    .START (0)
  ) u_div1 (
    .clk (clk),
    .en  (div_en),
    .q   (q1)
  );

  clk_div_phase #(
    .DIV   (DIV2),
    .START (START2)
  ) u_div2 (
    .clk (clk),
    .en  (div_en),
    .q   (q2)
  );

  // Gate with the registered lock flag as a second guard against any
  // divider output escaping while unlocked.
  assign out_if.locked   = (state_q == LOCK_DONE);
  assign out_if.clk_out1 = q1 && (state_q == LOCK_DONE);
  assign out_if.clk_out2 = q2 && (state_q == LOCK_DONE);

endmodule
`default_nettype wire

// File: tb/tb_clk_wiz.sv
`timescale 1ns/100ps
`default_nettype none
// ============================================================================
//  Module   : tb_clk_wiz
//  Purpose  : Self-checking bench for clk_wiz. Two instances: defaults
//             (6/6/3) and DIV1=4, DIV2=8, PHASE2=0. A cycle model pushes
//             expected outputs every clk_in edge; phase table and short
//             hand sequences cover lock timing, reset, glitch and phase.
//  Revision : 1.0  initial release
// ============================================================================
module tb_clk_wiz;
  import clk_wiz_pkg::*;

  localparam int LOCKN  = 64;
  localparam int A_DIV1 = 6, A_DIV2 = 6, A_ST2 = 3;  // (6-3)%6
  localparam int B_DIV1 = 4, B_DIV2 = 8, B_ST2 = 0;  // (8-0)%8

  logic clk = 1'b0;
  logic clk_n;
  logic resetn;
  assign clk_n = ~clk;
  always #2.5 clk = ~clk;

  clk_wiz_if if_a ();
  clk_wiz_if if_b ();

  clk_wiz dut_a (
    .clk_in1_p (clk),
    .clk_in1_n (clk_n),
    .resetn    (resetn),
    .out_if    (if_a.master)
  );

  clk_wiz #(
    .DIV1        (B_DIV1),
    .DIV2        (B_DIV2),
    .PHASE2      (B_ST2),
    .LOCK_CYCLES (LOCKN)
  ) dut_b (
    .clk_in1_p (clk),
    .clk_in1_n (clk_n),
    .resetn    (resetn),
    .out_if    (if_b.master)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [5:0] dut_bits();
    return {if_a.locked, if_a.clk_out1, if_a.clk_out2,
            if_b.locked, if_b.clk_out1, if_b.clk_out2};
  endfunction

  // ---------------- reference model + scoreboard ----------------
  // run: consecutive edges with resetn high (saturating); k: edges since lock.
  int         m_run = 0;
  int         m_k   = 0;
  logic       m_lk;
  logic [5:0] sb_q[$];

  always @(posedge clk) begin
    if (!resetn) begin
      m_run = 0;
      m_k   = 0;
    end else if (m_run == LOCKN) begin
      m_k = m_k + 1;
    end else begin
      m_run = m_run + 1;
    end
    m_lk = (m_run == LOCKN);
    sb_q.push_back({m_lk, m_lk && ((m_k % A_DIV1) < A_DIV1/2),
                          m_lk && (((m_k + A_ST2) % A_DIV2) < A_DIV2/2),
                    m_lk, m_lk && ((m_k % B_DIV1) < B_DIV1/2),
                          m_lk && (((m_k + B_ST2) % B_DIV2) < B_DIV2/2)});
  end

  // Per-cycle compare plus clk_out2 toggle spacing on the default instance.
  logic [5:0] sb_exp;
  int         cyc    = 0;
  int         last_t = 0;
  bit         have_t = 0;
  logic       prev2  = 1'b0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (sb_q.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      sb_exp = sb_q.pop_front();
      check("sb_cycle", {26'd0, dut_bits()}, {26'd0, sb_exp});
    end
    if (!if_a.locked) begin
      have_t = 0;
    end else if (if_a.clk_out2 !== prev2) begin
      if (have_t) check("out2_half_period", cyc - last_t, A_DIV2/2);
      have_t = 1;
      last_t = cyc;
    end
    prev2 = if_a.clk_out2;
  end

  // ---------------- phase table ----------------
  typedef struct {
    string      name;
    int         cycles;
    logic       rstn;
    logic [5:0] exp;   // {la, a1, a2, lb, b1, b2} after the last edge
  } vec_t;

  vec_t vecs[12];

  initial begin : watchdog
    #200us;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int   r1, n_r1;
    bit   have_r1;
    logic p1, p2;

    vecs[0]  = '{"reset_hold",      10,   1'b0, 6'b000_000};
    vecs[1]  = '{"pre_lock_63",     63,   1'b1, 6'b000_000};
    vecs[2]  = '{"lock_edge_64",    1,    1'b1, 6'b110_111};
    vecs[3]  = '{"steady_1000per",  6000, 1'b1, 6'b110_111};
    vecs[4]  = '{"reset_pulse",     1,    1'b0, 6'b000_000};
    vecs[5]  = '{"relock_63",       63,   1'b1, 6'b000_000};
    vecs[6]  = '{"relock_64",       1,    1'b1, 6'b110_111};
    vecs[7]  = '{"lock_plus3",      3,    1'b1, 6'b101_101};
    vecs[8]  = '{"reset_again",     5,    1'b0, 6'b000_000};
    vecs[9]  = '{"glitch_high_20",  20,   1'b1, 6'b000_000};
    vecs[10] = '{"glitch_low",      5,    1'b0, 6'b000_000};
    vecs[11] = '{"final_lock_64",   64,   1'b1, 6'b110_111};

    resetn = 1'b0;
    for (int i = 0; i < 12; i++) begin
      resetn = vecs[i].rstn;
      repeat (vecs[i].cycles) @(posedge clk);
      @(negedge clk);
      check(vecs[i].name, {26'd0, dut_bits()}, {26'd0, vecs[i].exp});
    end

    // Locked with k=0: clk_out1 rises every 6 cycles, clk_out2 3 cycles later.
    have_r1 = 0;
    n_r1    = 0;
    r1      = 0;
    p1      = if_a.clk_out1;
    p2      = if_a.clk_out2;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (if_a.clk_out1 && !p1) begin
        if (have_r1) check("out1_period", c - r1, A_DIV1);
        have_r1 = 1;
        r1      = c;
        n_r1++;
      end
      if (if_a.clk_out2 && !p2 && have_r1) check("out2_lag", c - r1, A_ST2);
      p1 = if_a.clk_out1;
      p2 = if_a.clk_out2;
    end
    check("out1_rises_seen", (n_r1 >= 9) ? 32'd1 : 32'd0, 32'd1);

    // Reset landing while clk_out1 is high: everything low at that edge.
    resetn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("reset_mid_high", {26'd0, dut_bits()}, 32'd0);
    resetn = 1'b1;
    repeat (4) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
